// File: rtl/uart_tx_unit.sv
// UART transmitter: byte FIFO in front of an 11-bit frame serialiser
// (start, D0..D7 LSB first, even parity, stop), advanced by the tx_tick strobe.
module uart_tx_unit #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_tick,
    input  logic                  wen,
    input  logic [FIFO_WIDTH-1:0] write_data,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_full,
    output logic                  tx_empty,
    output logic [2:0]            dbg_state_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (FIFO_WIDTH > 1) ? $clog2(FIFO_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(FIFO_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, empty_q;
    logic                  push, pop;
    logic [FIFO_WIDTH-1:0] head;

    state_t                state_q;
    logic [FIFO_WIDTH-1:0] sh_q;
    logic                  par_q;
    logic [BW-1:0]         bitcnt_q;
    logic                  tx_q, busy_q;

    // Host handshake: wen acts as valid and !tx_full as ready; a write with
    // tx_full high is dropped unless a frame start frees a slot that same cycle.
    assign head = mem_q[rd_ptr_q];
    assign pop  = tx_tick && !empty_q && ((state_q == IDLE) || (state_q == STOP));
    assign push = wen && (!full_q || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(FIFO_DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Every transition, and therefore every tx change, happens only on a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            par_q    <= 1'b0;
            bitcnt_q <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else if (tx_tick) begin
            case (state_q)
                IDLE: begin
                    if (!empty_q) begin
                        sh_q    <= head;
                        par_q   <= ^head;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                START: begin
                    tx_q     <= sh_q[0];
                    bitcnt_q <= '0;
                    state_q  <= DATA;
                end
                DATA: begin
                    sh_q     <= sh_q >> 1;
                    bitcnt_q <= bitcnt_q + BW'(1);
                    if (bitcnt_q == LAST_BIT) begin
                        tx_q    <= par_q;
                        state_q <= PARITY;
                    end else begin
                        tx_q <= sh_q[1];
                    end
                end
                PARITY: begin
                    tx_q    <= 1'b1;
                    state_q <= STOP;
                end
                STOP: begin
                    if (!empty_q) begin
                        sh_q    <= head;
                        par_q   <= ^head;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end else begin
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx          = tx_q;
    assign tx_busy     = busy_q;
    assign tx_full     = full_q;
    assign tx_empty    = empty_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed + randomized bench for uart_tx_unit: the tx line is sampled once per
// tick period and decoded into frames that are checked against expected bytes.
module tb_uart_tx_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       tx_tick;
    logic       wen;
    logic [7:0] write_data;
    logic       tx, tx_busy, tx_full, tx_empty;
    logic [2:0] dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic       line_q[$];
    bit         mon_busy = 1'b0;
    int         busy_drop = 0;

    uart_tx_unit #(.FIFO_WIDTH(8), .FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_tick     (tx_tick),
        .wen         (wen),
        .write_data  (write_data),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_full     (tx_full),
        .tx_empty    (tx_empty),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line order of a frame: index k is the k-th bit period on tx.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = ((b >> i) & 8'd1) != 8'd0;
            if (f[i+1]) ones++;
        end
        f[9]  = (ones % 2) == 1;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic step(input logic tk, input logic we, input logic [7:0] d);
        tx_tick = tk;
        wen = we;
        write_data = d;
        @(posedge clk);
        #1;
        if (tk && !rst) line_q.push_back(tx);
        if (mon_busy && !tx_busy) busy_drop++;
        tx_tick = 1'b0;
        wen = 1'b0;
    endtask

    task automatic run_ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap - 1) step(1'b0, 1'b0, 8'h00);
            step(1'b1, 1'b0, 8'h00);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        step(1'b0, 1'b1, b);
        exp_q.push_back(b);
    endtask

    // Decode n frames from the sampled line; last_gap = idle periods before the last one.
    task automatic check_frames(input string tag, input int n, output int last_gap);
        logic [10:0] got;
        last_gap = 0;
        for (int f = 0; f < n; f++) begin
            last_gap = 0;
            while (line_q.size() > 0 && line_q[0] == 1'b1) begin
                void'(line_q.pop_front());
                last_gap++;
            end
            if (line_q.size() < 11 || exp_q.size() == 0) begin
                chk({tag, "_frame_missing"}, line_q.size(), 11);
                return;
            end
            for (int k = 0; k < 11; k++) got[k] = line_q.pop_front();
            chk({tag, "_frame"}, got, frame_of(exp_q.pop_front()));
        end
    endtask

    task automatic check_line_idle(input string tag);
        int zeros;
        zeros = 0;
        foreach (line_q[k]) if (line_q[k] != 1'b1) zeros++;
        chk({tag, "_no_extra_frame"}, zeros, 0);
        chk({tag, "_exp_drained"}, exp_q.size(), 0);
        line_q.delete();
    endtask

    initial begin
        int gap;
        int written;
        logic [7:0] b;

        rst = 1'b1; tx_tick = 1'b0; wen = 1'b0; write_data = 8'h00;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        chk("reset_tx", tx, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_full", tx_full, 0);
        chk("reset_empty", tx_empty, 1);

        // Test 1: idle ticks, nothing queued
        for (int i = 0; i < 4; i++) begin
            run_ticks(1, 16);
            chk("idle_tx", tx, 1);
            chk("idle_busy", tx_busy, 0);
            chk("idle_empty", tx_empty, 1);
        end
        line_q.delete();

        // Test 2: 0xA5 written on a tick cycle; that tick must not start the frame
        step(1'b1, 1'b1, 8'hA5);
        exp_q.push_back(8'hA5);
        chk("tick_with_write_tx", tx, 1);
        chk("tick_with_write_busy", tx_busy, 0);
        chk("a5_reference", frame_of(8'hA5), 11'b10_1010_0101_0);
        run_ticks(14, 3);
        check_frames("a5", 1, gap);
        chk("a5_after_busy", tx_busy, 0);
        chk("a5_after_empty", tx_empty, 1);
        check_line_idle("a5");

        // Test 3: parity corners
        write_byte(8'h07);
        write_byte(8'h00);
        run_ticks(26, $urandom_range(1, 4));
        check_frames("parity", 2, gap);
        check_line_idle("parity");

        // Test 4: back-to-back frames on consecutive-cycle ticks
        write_byte(8'h11);
        write_byte(8'h22);
        step(1'b1, 1'b0, 8'h00);
        mon_busy = 1'b1;
        busy_drop = 0;
        run_ticks(21, 1);
        mon_busy = 1'b0;
        chk("b2b_busy_held", busy_drop, 0);
        run_ticks(4, 1);
        check_frames("b2b", 2, gap);
        chk("b2b_no_gap", gap, 0);
        chk("b2b_end_busy", tx_busy, 0);
        check_line_idle("b2b");

        // Test 5: fill with ticks off, overflow dropped, then write+pop while full
        for (int i = 0; i < 8; i++) write_byte(8'($urandom));
        chk("full_after_8", tx_full, 1);
        chk("full_not_empty", tx_empty, 0);
        step(1'b0, 1'b1, 8'hEE);
        chk("full_after_drop", tx_full, 1);
        b = 8'($urandom);
        step(1'b1, 1'b1, b);
        exp_q.push_back(b);
        chk("full_write_with_pop", tx_full, 1);
        run_ticks(110, $urandom_range(1, 3));
        check_frames("fifo", 9, gap);
        chk("fifo_end_empty", tx_empty, 1);
        chk("fifo_end_full", tx_full, 0);
        check_line_idle("fifo");

        // Test 6: reset during D0 of the second of three queued frames
        write_byte(8'h3C);
        write_byte(8'hC3);
        write_byte(8'h5A);
        run_ticks(13, 1);
        chk("pre_reset_busy", tx_busy, 1);
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        chk("abort_tx", tx, 1);
        chk("abort_busy", tx_busy, 0);
        chk("abort_empty", tx_empty, 1);
        chk("abort_full", tx_full, 0);
        check_frames("abort", 1, gap);
        chk("abort_partial_len", line_q.size(), 2);
        if (line_q.size() == 2) begin
            chk("abort_partial_start", line_q[0], 0);
            chk("abort_partial_d0", line_q[1], 8'hC3 & 8'h01);
        end
        line_q.delete();
        exp_q.delete();
        run_ticks(40, 1);
        check_line_idle("abort_after");

        // Test 7: random bytes written while ticks arrive at random
        written = 0;
        while (written < 8) begin
            b = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                step(1'($urandom_range(0, 1)), 1'b1, b);
                exp_q.push_back(b);
                written++;
            end else begin
                step(1'($urandom_range(0, 1)), 1'b0, 8'h00);
            end
        end
        run_ticks(100, 1);
        check_frames("random", 8, gap);
        chk("random_end_empty", tx_empty, 1);
        check_line_idle("random");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
